// File: rtl/button_press_decoder.sv
// Classifies debounced button presses as short or long and, when built with
// AUTO_REPEAT_EN defined, emits auto-repeat pulses while a long press is held.
module button_press_decoder #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic pressPulse,
  input  logic releasePulse,
  input  logic pressedLevel,
  output logic shortPress,
  output logic longPress,
  output logic repeatPulse,
  output logic holding
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PRESSED = 2'b01,
    S_LONG    = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             holding_q, holding_d;
  logic             conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + ONE_C;
  endfunction

  assign conflict = pressPulse & releasePulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      holdCnt_q <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      holding_q <= holding_d;
    end
  end

  // Simultaneous press and release edges are treated as noise and freeze everything.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      S_IDLE: begin
        if (pressPulse && !releasePulse) begin
          state_d   = S_PRESSED;
          holdCnt_d = ONE_C;
        end
      end
      S_PRESSED: begin
        if (!conflict) begin
          if (releasePulse || !pressedLevel) begin
            state_d   = S_IDLE;
            holdCnt_d = '0;
          end else if (holdCnt_q == LONG_C) begin
            state_d   = S_LONG;
            holdCnt_d = ONE_C;
          end else begin
            holdCnt_d = sat_inc(holdCnt_q, LONG_C);
          end
        end
      end
      S_LONG: begin
        if (!conflict) begin
          if (releasePulse || !pressedLevel) begin
            state_d   = S_IDLE;
            holdCnt_d = '0;
`ifdef AUTO_REPEAT_EN
          end else if (holdCnt_q == REP_C) begin
            holdCnt_d = ONE_C;
`endif
          end else begin
            holdCnt_d = sat_inc(holdCnt_q, REP_C);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        holdCnt_d = '0;
      end
    endcase
  end

  always_comb begin
    short_d   = (state_q == S_PRESSED) && !conflict && releasePulse;
    long_d    = (state_q == S_PRESSED) && !conflict && !releasePulse &&
                pressedLevel && (holdCnt_q == LONG_C);
`ifdef AUTO_REPEAT_EN
    repeat_d  = (state_q == S_LONG) && !conflict && !releasePulse &&
                pressedLevel && (holdCnt_q == REP_C);
`else
    repeat_d  = 1'b0;
`endif
    holding_d = (state_d == S_PRESSED) || (state_d == S_LONG);
  end

  assign shortPress  = short_q;
  assign longPress   = long_q;
  assign repeatPulse = repeat_q;
  assign holding     = holding_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboard bench for button_press_decoder (LONG=10, REPEAT=4, CNT_W=4).
module tb_button_press_decoder;

  localparam logic [2:0] K_SHORT = 3'b100;
  localparam logic [2:0] K_LONG  = 3'b010;
  localparam logic [2:0] K_REP   = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pressPulse = 1'b0;
  logic releasePulse = 1'b0;
  logic pressedLevel = 1'b0;
  logic shortPress, longPress, repeatPulse, holding;

  int   ecount = 0;
  int   checks = 0;
  int   errors = 0;
  int   e0;
  exp_t expq[$];
  exp_t mon_e;
  logic [2:0] mon_got;

  button_press_decoder #(
    .LONG_CYCLES(10),
    .REPEAT_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pressPulse(pressPulse),
    .releasePulse(releasePulse),
    .pressedLevel(pressedLevel),
    .shortPress(shortPress),
    .longPress(longPress),
    .repeatPulse(repeatPulse),
    .holding(holding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (shortPress || longPress || repeatPulse) begin
      mon_got = {shortPress, longPress, repeatPulse};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge=%0d got=%b required=none", ecount, mon_got);
      end else begin
        mon_e = expq.pop_front();
        if (mon_got !== mon_e.kind || ecount != mon_e.edge_n) begin
          errors++;
          $display("FAIL pulse got=%b@%0d required=%b@%0d",
                   mon_got, ecount, mon_e.kind, mon_e.edge_n);
        end
      end
    end
  end

  task automatic expect_ev(input logic [2:0] k, input int e);
    exp_t x;
    x.kind = k;
    x.edge_n = e;
    expq.push_back(x);
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    pressPulse   = 1'b1;
    pressedLevel = 1'b1;
    @(posedge clk);
    #1;
    e0 = ecount;
    pressPulse = 1'b0;
  endtask

  task automatic release_btn();
    releasePulse = 1'b1;
    pressedLevel = 1'b0;
    @(posedge clk);
    #1;
    releasePulse = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("reset_short", shortPress, 1'b0);
    chk("reset_long", longPress, 1'b0);
    chk("reset_repeat", repeatPulse, 1'b0);
    chk("reset_holding", holding, 1'b0);
    reset = 1'b0;
    idle(2);

    // Short press released at E0+3
    press();
    chk("t1_holding_e0", holding, 1'b1);
    idle(2);
    chk("t1_holding_e2", holding, 1'b1);
    expect_ev(K_SHORT, e0 + 3);
    release_btn();
    chk("t1_holding_after", holding, 1'b0);
    idle(4);

    // Long press held to E0+20
    press();
    expect_ev(K_LONG, e0 + 10);
`ifdef AUTO_REPEAT_EN
    expect_ev(K_REP, e0 + 14);
    expect_ev(K_REP, e0 + 18);
`endif
    idle(19);
    chk("t2_holding_e19", holding, 1'b1);
    release_btn();
    chk("t2_holding_after", holding, 1'b0);
    idle(4);

    // Release exactly at the long threshold wins
    press();
    idle(9);
    expect_ev(K_SHORT, e0 + 10);
    release_btn();
    chk("t3_holding_after", holding, 1'b0);
    idle(4);

    // Both pulses in IDLE, then release alone in IDLE
    pressPulse = 1'b1;
    releasePulse = 1'b1;
    pressedLevel = 1'b1;
    idle(1);
    pressPulse = 1'b0;
    releasePulse = 1'b0;
    pressedLevel = 1'b0;
    chk("t4_both_idle", holding, 1'b0);
    releasePulse = 1'b1;
    idle(1);
    releasePulse = 1'b0;
    chk("t4_rel_idle", holding, 1'b0);
    idle(2);

    // Second press at E0+5 does not restart the hold count
    press();
    expect_ev(K_LONG, e0 + 10);
    idle(4);
    pressPulse = 1'b1;
    idle(1);
    pressPulse = 1'b0;
    chk("t4_holding_repress", holding, 1'b1);
    idle(5);
    chk("t4_holding_long", holding, 1'b1);
    release_btn();
    chk("t4_holding_after", holding, 1'b0);
    idle(4);

    // Level drops without release pulse: silent abort
    press();
    idle(3);
    pressedLevel = 1'b0;
    idle(1);
    chk("t5_desync_holding", holding, 1'b0);
    idle(12);

    // Reset mid-hold drops the press
    press();
    idle(5);
    reset = 1'b1;
    idle(1);
    chk("t5_rst_short", shortPress, 1'b0);
    chk("t5_rst_long", longPress, 1'b0);
    chk("t5_rst_repeat", repeatPulse, 1'b0);
    chk("t5_rst_holding", holding, 1'b0);
    reset = 1'b0;
    pressedLevel = 1'b0;
    idle(15);

    // Held 30 edges
    press();
    expect_ev(K_LONG, e0 + 10);
`ifdef AUTO_REPEAT_EN
    expect_ev(K_REP, e0 + 14);
    expect_ev(K_REP, e0 + 18);
    expect_ev(K_REP, e0 + 22);
    expect_ev(K_REP, e0 + 26);
`endif
    idle(29);
    chk("t6_holding_e29", holding, 1'b1);
    release_btn();
    chk("t6_holding_after", holding, 1'b0);
    idle(10);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
